// File: rtl/mux16_rr_scheduler.sv
// Round-robin scheduler for a shared 16:1 mux: grants one requester at a time,
// drives the mux select and handshakes the selected lane downstream.
module mux16_rr_scheduler #(
    parameter int unsigned BURST_LEN = 1,
    parameter int unsigned CNT_W     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req,
    output logic [15:0] ack,
    output logic [3:0]  sel,
    output logic [15:0] grant,
    output logic        busy,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int unsigned N_LANES = 16;
    localparam int unsigned SEL_W   = 4;

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    state_t             state_q;
    logic [SEL_W-1:0]   ptr_q;
    logic [SEL_W-1:0]   sel_q;
    logic [N_LANES-1:0] grant_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               win_found_c;
    logic [SEL_W-1:0]   win_idx_c;
    logic [SEL_W-1:0]   scan_idx_c;
    logic               accept_c;
    logic               last_beat_c;

    // Rotating priority scan: the lowest offset from ptr with a request wins.
    always_comb begin
        win_found_c = 1'b0;
        win_idx_c   = '0;
        scan_idx_c  = '0;
        for (int i = N_LANES - 1; i >= 0; i--) begin
            scan_idx_c = ptr_q + SEL_W'(i);
            if (req[scan_idx_c]) begin
                win_found_c = 1'b1;
                win_idx_c   = scan_idx_c;
            end
        end
    end

    // Handshake decode; the reset cycle never presents or accepts a beat.
    always_comb begin
        busy        = (state_q == S_GRANT);
        out_valid   = busy & req[sel_q] & ~rst;
        accept_c    = out_valid & out_ready;
        last_beat_c = (cnt_q == CNT_W'(BURST_LEN - 1));
        ack         = accept_c ? grant_q : '0;
        sel         = sel_q;
        grant       = grant_q;
    end

    // Grant FSM: arbitrate in IDLE, hold in GRANT until burst end or withdraw.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            grant_q <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (win_found_c) begin
                        state_q <= S_GRANT;
                        sel_q   <= win_idx_c;
                        grant_q <= N_LANES'(1) << win_idx_c;
                        cnt_q   <= '0;
                    end
                end
                S_GRANT: begin
                    if (!req[sel_q] || (accept_c && last_beat_c)) begin
                        state_q <= S_IDLE;
                        ptr_q   <= sel_q + SEL_W'(1);
                        grant_q <= '0;
                        cnt_q   <= '0;
                    end else if (accept_c) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux16_rr_scheduler.sv
// Bench for mux16_rr_scheduler: three burst lengths share one stimulus stream,
// each checked every cycle against a lane-level round-robin model.
module tb_mux16_rr_scheduler;

    logic        clk;
    logic        rst;
    logic [15:0] req;
    logic        out_ready;

    logic [15:0] ack_w   [3];
    logic [15:0] grant_w [3];
    logic [3:0]  sel_w   [3];
    logic        busy_w  [3];
    logic        valid_w [3];

    int unsigned bl_tab [3] = '{1, 3, 4};

    int n_tests = 0;
    int n_fail  = 0;
    bit started = 0;

    mux16_rr_scheduler #(.BURST_LEN(1), .CNT_W(8)) u_bl1 (
        .clk(clk), .rst(rst), .req(req), .ack(ack_w[0]), .sel(sel_w[0]),
        .grant(grant_w[0]), .busy(busy_w[0]), .out_valid(valid_w[0]), .out_ready(out_ready));
    mux16_rr_scheduler #(.BURST_LEN(3), .CNT_W(8)) u_bl3 (
        .clk(clk), .rst(rst), .req(req), .ack(ack_w[1]), .sel(sel_w[1]),
        .grant(grant_w[1]), .busy(busy_w[1]), .out_valid(valid_w[1]), .out_ready(out_ready));
    mux16_rr_scheduler #(.BURST_LEN(4), .CNT_W(8)) u_bl4 (
        .clk(clk), .rst(rst), .req(req), .ack(ack_w[2]), .sel(sel_w[2]),
        .grant(grant_w[2]), .busy(busy_w[2]), .out_valid(valid_w[2]), .out_ready(out_ready));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit m_busy  [3];
    int m_lane  [3];
    int m_beats [3];
    int m_ptr   [3];

    function automatic int pick(input logic [15:0] r, input int ptr);
        for (int k = 0; k < 16; k++) begin
            if (r[(ptr + k) % 16]) return (ptr + k) % 16;
        end
        return -1;
    endfunction

    function automatic logic exp_valid(input int j);
        return m_busy[j] && req[m_lane[j]] && !rst;
    endfunction

    always @(posedge clk) begin
        for (int j = 0; j < 3; j++) begin
            if (rst) begin
                m_busy[j] = 0; m_lane[j] = 0; m_beats[j] = 0; m_ptr[j] = 0;
            end else if (!m_busy[j]) begin
                if (pick(req, m_ptr[j]) >= 0) begin
                    m_lane[j]  = pick(req, m_ptr[j]);
                    m_busy[j]  = 1;
                    m_beats[j] = 0;
                end
            end else if (!req[m_lane[j]]) begin
                m_busy[j] = 0;
                m_ptr[j]  = (m_lane[j] + 1) % 16;
            end else if (out_ready) begin
                m_beats[j] = m_beats[j] + 1;
                if (m_beats[j] == int'(bl_tab[j])) begin
                    m_busy[j] = 0;
                    m_ptr[j]  = (m_lane[j] + 1) % 16;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle compare of all three instances against the model.
    always @(negedge clk) begin
        if (started) begin
            for (int j = 0; j < 3; j++) begin
                logic [15:0] eg;
                logic        ev;
                eg = m_busy[j] ? (16'd1 << m_lane[j]) : 16'd0;
                ev = exp_valid(j);
                chk($sformatf("model.u%0d.sel", j),   32'(sel_w[j]),   32'(m_lane[j]));
                chk($sformatf("model.u%0d.grant", j), 32'(grant_w[j]), 32'(eg));
                chk($sformatf("model.u%0d.busy", j),  32'(busy_w[j]),  32'(m_busy[j]));
                chk($sformatf("model.u%0d.valid", j), 32'(valid_w[j]), 32'(ev));
                chk($sformatf("model.u%0d.ack", j),   32'(ack_w[j]),   32'((ev && out_ready) ? eg : 16'd0));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = '0; out_ready = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    int lanes[$];
    int acks;
    bit prev_busy;

    initial begin
        rst = 1'b1; req = '0; out_ready = 1'b0;
        step();
        started = 1;
        step();
        rst = 1'b0;
        #1;
        chk("reset.busy",  32'(busy_w[0]),  32'd0);
        chk("reset.grant", 32'(grant_w[0]), 32'd0);
        chk("reset.sel",   32'(sel_w[0]),   32'd0);
        chk("reset.valid", 32'(valid_w[0]), 32'd0);
        chk("reset.ack",   32'(ack_w[0]),   32'd0);

        // single requester, BURST_LEN=1
        req = 16'h0010; out_ready = 1'b1;
        step();
        chk("single.sel",   32'(sel_w[0]),   32'd4);
        chk("single.grant", 32'(grant_w[0]), 32'h0010);
        chk("single.valid", 32'(valid_w[0]), 32'd1);
        chk("single.ack",   32'(ack_w[0]),   32'h0010);
        step();
        chk("single.idle", 32'(busy_w[0]), 32'd0);
        req = '0;
        step();

        // round robin across all lanes
        do_reset();
        req = 16'hFFFF; out_ready = 1'b1;
        lanes.delete();
        prev_busy = 0;
        for (int c = 0; c < 34; c++) begin
            step();
            if (busy_w[0]) begin
                lanes.push_back(int'(sel_w[0]));
                chk("rr.ack", 32'(ack_w[0]), 32'(16'd1 << sel_w[0]));
            end
            chk("rr.bubble", 32'(prev_busy && busy_w[0]), 32'd0);
            prev_busy = busy_w[0];
        end
        chk("rr.count", 32'(lanes.size()), 32'd17);
        for (int k = 0; k < lanes.size(); k++) chk($sformatf("rr.order%0d", k), 32'(lanes[k]), 32'(k % 16));

        // burst of 3 with backpressure on the BURST_LEN=3 instance
        do_reset();
        req = 16'h0100; out_ready = 1'b0;
        step();
        acks = 0;
        for (int p = 0; p < 5; p++) begin
            logic [4:0] pat;
            pat = 5'b11001;
            out_ready = pat[p];
            #1;
            chk("burst.held", 32'(busy_w[1]), 32'd1);
            chk("burst.ack",  32'(ack_w[1]),  32'(pat[p] ? 16'h0100 : 16'h0000));
            if (ack_w[1] != 0) acks++;
            step();
        end
        chk("burst.acks", 32'(acks), 32'd3);
        chk("burst.released", 32'(busy_w[1]), 32'd0);
        req = 16'h0300;
        step();
        chk("burst.ptr9", 32'(sel_w[1]), 32'd9);

        // wrap-around on BURST_LEN=1
        do_reset();
        req = 16'h4000; out_ready = 1'b1;
        step();
        chk("wrap.l14", 32'(sel_w[0]), 32'd14);
        step();
        req = 16'h8001;
        step(); chk("wrap.first15", 32'(sel_w[0]), 32'd15);
        step();
        step(); chk("wrap.then0", 32'(sel_w[0]), 32'd0);
        step();
        step(); chk("wrap.again15", 32'(sel_w[0]), 32'd15);

        // withdraw on BURST_LEN=1
        do_reset();
        req = 16'h0008; out_ready = 1'b0;
        step();
        chk("wd.sel3", 32'(sel_w[0]), 32'd3);
        req = 16'h0024;
        #1;
        chk("wd.noack",   32'(ack_w[0]),   32'd0);
        chk("wd.novalid", 32'(valid_w[0]), 32'd0);
        step();
        chk("wd.idle", 32'(busy_w[0]), 32'd0);
        out_ready = 1'b1;
        step(); chk("wd.lane5", 32'(sel_w[0]), 32'd5);
        step();
        step(); chk("wd.lane2", 32'(sel_w[0]), 32'd2);

        // reset mid-burst on BURST_LEN=4
        do_reset();
        req = 16'h0040; out_ready = 1'b1;
        step(); chk("rmb.ack1", 32'(ack_w[2]), 32'h0040);
        step(); chk("rmb.ack2", 32'(ack_w[2]), 32'h0040);
        step();
        rst = 1'b1;
        #1;
        chk("rmb.rstack", 32'(ack_w[2]), 32'd0);
        step();
        rst = 1'b0; req = 16'h0041;
        #1;
        chk("rmb.grant", 32'(grant_w[2]), 32'd0);
        chk("rmb.busy",  32'(busy_w[2]),  32'd0);
        chk("rmb.ack",   32'(ack_w[2]),   32'd0);
        step();
        chk("rmb.lane0", 32'(sel_w[2]), 32'd0);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            case ($urandom_range(0, 3))
                0:       req = 16'd1 << $urandom_range(0, 15);
                1:       req = 16'h0000;
                default: req = 16'($urandom);
            endcase
            out_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
